// File: rtl/alu_arb_ctrl.sv
// Two-requester arbiter/sequencer that owns the shared combinational ALU inputs.
// Build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties and the pointer is not built.
module alu_arb_ctrl #(
    parameter int WIDTH = 4,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic [OPW-1:0]   req1_op,
    input  logic             req0_cin,
    input  logic             req1_cin,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_control,
    output logic             alu_carryin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t state, state_nxt;
    logic   pick;
    logic   grant;
    logic   accept;
    logic   done;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign pick = ~req_valid[0];
`else
    logic ptr;

    // Contention goes to the pointer owner; otherwise to whichever requester is valid.
    assign pick = (req_valid == 2'b11) ? ptr : req_valid[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (done) begin
            ptr <= ~grant;
        end
    end
`endif

    assign accept = (state == IDLE) && req_valid[pick];
    assign done   = (state == RESP) && rsp_ready[grant];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    req_ready[pick] = 1'b1;
                    state_nxt       = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid[grant] = 1'b1;
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are latched on acceptance and left in place afterwards; the
    // ALU output is sampled at the end of the single EXEC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            alu_carryin <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
        end else begin
            if (accept) begin
                grant       <= pick;
                alu_a       <= pick ? req1_a   : req0_a;
                alu_b       <= pick ? req1_b   : req0_b;
                alu_control <= pick ? req1_op  : req0_op;
                alu_carryin <= pick ? req1_cin : req0_cin;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_flags  <= {alu_n, alu_z, alu_c, alu_v};
            end
        end
    end
endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed bench for alu_arb_ctrl with a behavioural 4-bit ALU on the alu_* nets.
module tb_alu_arb_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [3:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
    logic [2:0] req0_op = '0, req1_op = '0;
    logic       req0_cin = 1'b0, req1_cin = 1'b0;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready = 2'b00;
    logic [3:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_control;
    logic       alu_carryin;
    logic [3:0] alu_result;
    logic       alu_n, alu_z, alu_c, alu_v;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    alu_arb_ctrl #(.WIDTH(4), .OPW(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op), .req0_cin(req0_cin), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_carryin(alu_carryin),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Returns {result[3:0], N, Z, C, V}.
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op, input logic cin);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        logic       v;
        s = 5'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
                r = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
                r = s[3:0]; c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = {a[2:0], 1'b0};
            default: r = {1'b0, a[3:1]};
        endcase
        return {r, r[3], (r == 4'd0), c, v};
    endfunction

    always_comb begin
        {alu_result, alu_n, alu_z, alu_c, alu_v} = alu_fn(alu_a, alu_b, alu_control, alu_carryin);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] exp;

        // Reset state
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_alu_ops", {alu_a, alu_b, alu_control, alu_carryin}, 32'h0);
        chk("rst_rsp", {rsp_result, rsp_flags}, 32'h0);
        rst = 1'b0;
        tick();

        // Add F+F, then backpressure and wrong-requester ready
        req0_a = 4'hF; req0_b = 4'hF; req0_op = 3'd0; req0_cin = 1'b0;
        req_valid = 2'b01;
        #1;
        chk("add_req_ready", 32'(req_ready), 32'h1);
        chk("add_idle_busy", 32'(busy), 32'h0);
        tick();
        req_valid = 2'b00;
        chk("add_exec_busy", 32'(busy), 32'h1);
        chk("add_exec_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("add_alu_regs", {alu_a, alu_b, alu_control, alu_carryin}, {4'hF, 4'hF, 3'd0, 1'b0});
        tick();
        chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("add_result", 32'(rsp_result), 32'hE);
        chk("add_flags", 32'(rsp_flags), 32'b1010);
        for (int i = 0; i < 5; i++) begin
            rsp_ready = (i < 2) ? 2'b00 : 2'b10;
            req_valid = (i == 3) ? 2'b10 : 2'b00;
            tick();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_result", 32'(rsp_result), 32'hE);
            chk("bp_flags", 32'(rsp_flags), 32'b1010);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_busy", 32'(busy), 32'h1);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        tick();
        chk("bp_release_valid", 32'(rsp_valid), 32'h0);
        chk("bp_release_busy", 32'(busy), 32'h0);
        chk("alu_a_kept", 32'(alu_a), 32'hF);
        rsp_ready = 2'b00;

        // Tie after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_a = 4'd1; req0_b = 4'd8; req0_op = 3'd0; req0_cin = 1'b0;
        req1_a = 4'd2; req1_b = 4'd9; req1_op = 3'd0; req1_cin = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("tie_first_ready", 32'(req_ready), 32'h1);
        tick();
        chk("tie_req0_ops", {alu_a, alu_b}, {4'd1, 4'd8});
        chk("tie_exec_ready", 32'(req_ready), 32'h0);
        tick();
        chk("tie_req0_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("tie_req0_rsp", {rsp_result, rsp_flags}, {4'h9, 4'b1000});
        rsp_ready = 2'b01;
        tick();
        #1;
        chk("tie_done_busy", 32'(busy), 32'h0);
`ifdef ALU_ARB_FIXED_PRIO_EN
        chk("tie_fixed_ready", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
`else
        chk("tie_second_ready", 32'(req_ready), 32'h2);
        rsp_ready = 2'b10;
        tick();
        chk("tie_req1_ops", {alu_a, alu_b}, {4'd2, 4'd9});
        tick();
        chk("tie_req1_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("tie_req1_rsp", {rsp_result, rsp_flags}, {4'hB, 4'b1000});
        tick();
        #1;
        chk("tie_third_ready", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        tick();
`endif

        // Opcode sweep on requester 1
        rsp_ready = 2'b10;
        for (int op = 0; op < 8; op++) begin
            for (int j = 0; j < 4; j++) begin
                req1_a   = 4'(j);
                req1_b   = 4'(j + 7);
                req1_op  = 3'(op);
                req1_cin = 1'(j);
                exp      = alu_fn(4'(j), 4'(j + 7), 3'(op), 1'(j));
                req_valid = 2'b10;
                #1;
                chk("sw_req_ready", 32'(req_ready), 32'h2);
                tick();
                req_valid = 2'b00;
                chk("sw_alu_control", 32'(alu_control), 32'(op));
                tick();
                chk("sw_rsp_valid", 32'(rsp_valid), 32'h2);
                chk("sw_rsp", {rsp_result, rsp_flags}, 32'(exp));
                tick();
                chk("sw_done", 32'(rsp_valid), 32'h0);
            end
        end

        // Reset during EXEC
        rsp_ready = 2'b01;
        req0_a = 4'd3; req0_b = 4'd4; req0_op = 3'd2; req0_cin = 1'b1;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        chk("rx_exec_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("rx_busy", 32'(busy), 32'h0);
        chk("rx_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rx_alu_regs", {alu_a, alu_b, alu_control, alu_carryin}, 32'h0);
        chk("rx_rsp", {rsp_result, rsp_flags}, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rx_no_rsp", {busy, rsp_valid}, 32'h0);
        end
        req0_a = 4'd5; req0_b = 4'd2; req0_op = 3'd0; req0_cin = 1'b0;
        req_valid = 2'b01;
        #1;
        chk("rx_next_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        tick();
        chk("rx_next_valid", 32'(rsp_valid), 32'h1);
        chk("rx_next_rsp", {rsp_result, rsp_flags}, {4'h7, 4'b0000});
        tick();
        chk("rx_next_done", {busy, rsp_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
